// File: rtl/nibble_exec_ctrl_if.sv
// Bus between the fetch register/PC/ROM side and the nibble decode/execute stage.
interface nibble_exec_ctrl_if #(
  parameter int unsigned ACC_W  = 4,
  parameter int unsigned ADDR_W = 12
);
  logic [3:0]              instr;
  logic [ACC_W-1:0]        oprnd;
  logic [ADDR_W-ACC_W-1:0] program_byte;
  logic [ACC_W-1:0]        data_in;
  logic                    en_pc;
  logic                    en_fetch;
  logic                    load_pc;
  logic [ADDR_W-1:0]       load_addr;
  logic [ACC_W-1:0]        acc;
  logic                    c_flag;
  logic                    z_flag;
  logic [ACC_W-1:0]        out_port;
  logic                    out_valid;
  logic                    halted;

  modport master (
    output instr, oprnd, program_byte, data_in,
    input  en_pc, en_fetch, load_pc, load_addr, acc, c_flag, z_flag,
           out_port, out_valid, halted
  );

  modport slave (
    input  instr, oprnd, program_byte, data_in,
    output en_pc, en_fetch, load_pc, load_addr, acc, c_flag, z_flag,
           out_port, out_valid, halted
  );
endinterface

// File: rtl/nibble_exec_ctrl.sv
// Decode/execute controller for a 4-bit accumulator ISA; sequences PC and fetch
// register and resolves two-byte jumps using the ROM byte at the current PC.
module nibble_exec_ctrl #(
  parameter int unsigned ACC_W  = 4,
  parameter int unsigned ADDR_W = 12
) (
  input logic              clk,
  input logic              reset,
  nibble_exec_ctrl_if.slave bus
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_ANDI = 4'h4;
  localparam logic [3:0] OP_ORI  = 4'h5;
  localparam logic [3:0] OP_XORI = 4'h6;
  localparam logic [3:0] OP_CMPI = 4'h7;
  localparam logic [3:0] OP_IN   = 4'h8;
  localparam logic [3:0] OP_OUT  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_JNC  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JNZ  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_ADDR  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               c_q, c_d;
  logic               z_q, z_d;
  logic [ACC_W-1:0]   out_port_q, out_port_d;
  logic               out_valid_q, out_valid_d;
  logic               halted_q, halted_d;

  logic               en_pc_c, en_fetch_c, load_pc_c;
  logic [ADDR_W-1:0]  load_addr_c;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   diff;
  logic [ACC_W-1:0]   logic_res;
  logic               borrow;
  logic               taken;

  // Arithmetic shared by ADDI/SUBI/CMPI
  assign sum    = {1'b0, acc_q} + {1'b0, bus.oprnd};
  assign diff   = acc_q - bus.oprnd;
  assign borrow = (acc_q < bus.oprnd);

  always_comb begin
    taken = 1'b0;
    case (bus.instr)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = c_q;
      OP_JNC:  taken = ~c_q;
      OP_JZ:   taken = z_q;
      OP_JNZ:  taken = ~z_q;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    logic_res = '0;
    case (bus.instr)
      OP_ANDI: logic_res = acc_q & bus.oprnd;
      OP_ORI:  logic_res = acc_q | bus.oprnd;
      OP_XORI: logic_res = acc_q ^ bus.oprnd;
      default: logic_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    c_d         = c_q;
    z_d         = z_q;
    out_port_d  = out_port_q;
    out_valid_d = 1'b0;
    en_pc_c     = 1'b0;
    en_fetch_c  = 1'b0;
    load_pc_c   = 1'b0;
    load_addr_c = '0;

    case (state_q)
      S_FETCH: begin
        en_fetch_c = 1'b1;
        en_pc_c    = 1'b1;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (bus.instr)
          OP_NOP: ;
          OP_LIT: acc_d = bus.oprnd;
          OP_ADDI: begin
            {c_d, acc_d} = sum;
            z_d          = (sum[ACC_W-1:0] == '0);
          end
          OP_SUBI: begin
            acc_d = diff;
            c_d   = borrow;
            z_d   = (diff == '0);
          end
          OP_ANDI, OP_ORI, OP_XORI: begin
            acc_d = logic_res;
            c_d   = 1'b0;
            z_d   = (logic_res == '0);
          end
          OP_CMPI: begin
            c_d = borrow;
            z_d = (diff == '0);
          end
          OP_IN: begin
            acc_d = bus.data_in;
            z_d   = (bus.data_in == '0);
          end
          OP_OUT: begin
            out_port_d  = acc_q;
            out_valid_d = 1'b1;
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_ADDR;
        endcase
      end
      S_ADDR: begin
        state_d = S_FETCH;
        if (taken) begin
          load_pc_c   = 1'b1;
          load_addr_c = ADDR_W'({bus.oprnd, bus.program_byte});
        end else begin
          en_pc_c = 1'b1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      acc_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  // Sequencing controls are silenced while reset is held
  assign bus.en_pc     = en_pc_c & ~reset;
  assign bus.en_fetch  = en_fetch_c & ~reset;
  assign bus.load_pc   = load_pc_c & ~reset;
  assign bus.load_addr = reset ? '0 : load_addr_c;
  assign bus.acc       = acc_q;
  assign bus.c_flag    = c_q;
  assign bus.z_flag    = z_q;
  assign bus.out_port  = out_port_q;
  assign bus.out_valid = out_valid_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_nibble_exec_ctrl.sv
// Directed bench for nibble_exec_ctrl with a behavioural PC, fetch register and ROM.
module tb_nibble_exec_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din = 4'h0;
  logic [11:0] pc;
  logic [7:0]  fetch_q;
  logic [7:0]  rom [4096];
  int passed = 0;
  int total  = 0;

  nibble_exec_ctrl_if bus ();

  nibble_exec_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Environment: program counter and fetch register driven by the DUT controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= 12'h000;
      fetch_q <= 8'h00;
    end else begin
      if (bus.load_pc)     pc <= bus.load_addr;
      else if (bus.en_pc)  pc <= pc + 12'd1;
      if (bus.en_fetch)    fetch_q <= rom[pc];
    end
  end

  assign bus.instr        = fetch_q[7:4];
  assign bus.oprnd        = fetch_q[3:0];
  assign bus.program_byte = rom[pc];
  assign bus.data_in      = din;

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic start_run();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h23;
    start_run();
    total++; if ({bus.en_fetch, bus.en_pc} !== 2'b11) $display("FAIL rst_first_fetch: got %b expected 11", {bus.en_fetch, bus.en_pc}); else passed++;
    nxt(3);
    total++; if (bus.acc !== 4'h5) $display("FAIL rst_lit5: acc got %h expected 5", bus.acc); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({bus.acc, bus.c_flag, bus.z_flag} !== 6'b0) $display("FAIL rst_regs: acc/c/z got %b expected 000000", {bus.acc, bus.c_flag, bus.z_flag}); else passed++;
    total++; if ({bus.en_fetch, bus.en_pc, bus.load_pc} !== 3'b000) $display("FAIL rst_ctrl_low: got %b expected 000", {bus.en_fetch, bus.en_pc, bus.load_pc}); else passed++;
    nxt(2);
    total++; if ({bus.acc, bus.en_fetch, bus.en_pc} !== 6'b0) $display("FAIL rst_abort: acc/en got %b expected 000000", {bus.acc, bus.en_fetch, bus.en_pc}); else passed++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({bus.en_fetch, bus.en_pc, pc} !== {2'b11, 12'h000}) $display("FAIL rst_release: en=%b pc=%h expected en=11 pc=000", {bus.en_fetch, bus.en_pc}, pc); else passed++;
  endtask

  task automatic test_add();
    clear_rom();
    rom[0] = 8'h19; rom[1] = 8'h28;
    start_run();
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.en_fetch !== ((i % 2) == 0)) $display("FAIL add_fetch_cycle%0d: en_fetch got %b expected %b", i, bus.en_fetch, (i % 2) == 0); else passed++;
      if (i == 2) begin
        total++; if (bus.acc !== 4'h9) $display("FAIL add_lit9: acc got %h expected 9", bus.acc); else passed++;
      end
      nxt(1);
    end
    total++; if ({bus.acc, bus.c_flag, bus.z_flag} !== {4'h1, 1'b1, 1'b0}) $display("FAIL add_result: acc/c/z got %h/%b/%b expected 1/1/0", bus.acc, bus.c_flag, bus.z_flag); else passed++;
  endtask

  task automatic test_logic();
    clear_rom();
    rom[0] = 8'h1C; rom[1] = 8'h25; rom[2] = 8'h43; rom[3] = 8'h61; rom[4] = 8'h56;
    start_run();
    nxt(4);
    total++; if ({bus.acc, bus.c_flag, bus.z_flag} !== {4'h1, 1'b1, 1'b0}) $display("FAIL log_addi: got %h/%b/%b expected 1/1/0", bus.acc, bus.c_flag, bus.z_flag); else passed++;
    nxt(2);
    total++; if ({bus.acc, bus.c_flag, bus.z_flag} !== {4'h1, 1'b0, 1'b0}) $display("FAIL log_andi: got %h/%b/%b expected 1/0/0", bus.acc, bus.c_flag, bus.z_flag); else passed++;
    nxt(2);
    total++; if ({bus.acc, bus.c_flag, bus.z_flag} !== {4'h0, 1'b0, 1'b1}) $display("FAIL log_xori: got %h/%b/%b expected 0/0/1", bus.acc, bus.c_flag, bus.z_flag); else passed++;
    nxt(2);
    total++; if ({bus.acc, bus.c_flag, bus.z_flag} !== {4'h6, 1'b0, 1'b0}) $display("FAIL log_ori: got %h/%b/%b expected 6/0/0", bus.acc, bus.c_flag, bus.z_flag); else passed++;
  endtask

  task automatic test_jz_taken();
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'h33; rom[2] = 8'hD4; rom[3] = 8'hA5; rom[12'h4A5] = 8'h17;
    start_run();
    nxt(5);
    total++; if ({bus.acc, bus.c_flag, bus.z_flag, bus.load_pc} !== {4'h0, 1'b0, 1'b1, 1'b0}) $display("FAIL jz_exec: acc/c/z/ld got %h/%b/%b/%b expected 0/0/1/0", bus.acc, bus.c_flag, bus.z_flag, bus.load_pc); else passed++;
    nxt(1);
    total++; if ({bus.load_pc, bus.en_pc, bus.load_addr} !== {2'b10, 12'h4A5}) $display("FAIL jz_addr: ld/en=%b addr=%h expected 10 4a5", {bus.load_pc, bus.en_pc}, bus.load_addr); else passed++;
    nxt(1);
    total++; if ({pc, bus.en_fetch, bus.load_addr} !== {12'h4A5, 1'b1, 12'h000}) $display("FAIL jz_target: pc=%h en_fetch=%b load_addr=%h expected 4a5 1 000", pc, bus.en_fetch, bus.load_addr); else passed++;
    nxt(2);
    total++; if (bus.acc !== 4'h7) $display("FAIL jz_target_exec: acc got %h expected 7", bus.acc); else passed++;
  endtask

  task automatic test_jc_not_taken();
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h72; rom[2] = 8'hB1; rom[3] = 8'h20; rom[4] = 8'h1E; rom[12'h120] = 8'h13;
    start_run();
    nxt(5);
    total++; if ({bus.acc, bus.c_flag, bus.z_flag} !== {4'h5, 1'b0, 1'b0}) $display("FAIL jc_cmpi: acc/c/z got %h/%b/%b expected 5/0/0", bus.acc, bus.c_flag, bus.z_flag); else passed++;
    nxt(1);
    total++; if ({bus.load_pc, bus.en_pc, bus.en_fetch, bus.load_addr} !== {3'b010, 12'h000}) $display("FAIL jc_addr: ld/en_pc/en_f=%b addr=%h expected 010 000", {bus.load_pc, bus.en_pc, bus.en_fetch}, bus.load_addr); else passed++;
    nxt(1);
    total++; if (pc !== 12'h004) $display("FAIL jc_skip: pc got %h expected 004", pc); else passed++;
    nxt(2);
    total++; if (bus.acc !== 4'hE) $display("FAIL jc_next_exec: acc got %h expected e", bus.acc); else passed++;
  endtask

  task automatic test_io();
    int cnt;
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h90;
    din = 4'hC;
    start_run();
    nxt(2);
    total++; if ({bus.acc, bus.z_flag} !== {4'hC, 1'b0}) $display("FAIL io_in: acc/z got %h/%b expected c/0", bus.acc, bus.z_flag); else passed++;
    nxt(1);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL io_valid_exec: got %b expected 0", bus.out_valid); else passed++;
    nxt(1);
    total++; if ({bus.out_valid, bus.out_port} !== {1'b1, 4'hC}) $display("FAIL io_out: valid/port got %b/%h expected 1/c", bus.out_valid, bus.out_port); else passed++;
    cnt = 1;
    for (int i = 0; i < 8; i++) begin
      nxt(1);
      if (bus.out_valid === 1'b1) cnt++;
    end
    total++; if (cnt !== 1) $display("FAIL io_valid_once: strobes got %0d expected 1", cnt); else passed++;
    din = 4'h0;
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 8'hF0; rom[1] = 8'h13;
    start_run();
    nxt(1);
    total++; if (bus.halted !== 1'b0) $display("FAIL halt_exec: halted got %b expected 0", bus.halted); else passed++;
    for (int i = 0; i < 20; i++) begin
      nxt(1);
      total++; if ({bus.halted, bus.en_pc, bus.en_fetch, bus.load_pc} !== 4'b1000) $display("FAIL halt_cycle%0d: h/en_pc/en_f/ld got %b expected 1000", i, {bus.halted, bus.en_pc, bus.en_fetch, bus.load_pc}); else passed++;
    end
    total++; if (pc !== 12'h001) $display("FAIL halt_pc_frozen: pc got %h expected 001", pc); else passed++;
    reset = 1'b1;
    #1;
    total++; if (bus.halted !== 1'b0) $display("FAIL halt_reset: halted got %b expected 0", bus.halted); else passed++;
    rom[0] = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({bus.en_fetch, bus.en_pc} !== 2'b11) $display("FAIL halt_resume: en got %b expected 11", {bus.en_fetch, bus.en_pc}); else passed++;
    nxt(4);
    total++; if ({bus.acc, bus.halted} !== {4'h3, 1'b0}) $display("FAIL halt_resume_exec: acc/halted got %h/%b expected 3/0", bus.acc, bus.halted); else passed++;
  endtask

  initial begin
    clear_rom();
    nxt(2);
    test_reset();
    test_add();
    test_logic();
    test_jz_taken();
    test_jc_not_taken();
    test_io();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
